cpu_control_seq: RTL and testbench

Multi-cycle control sequencer for the simple RISC datapath, succeeding the single-instruction wait/decode controller. Fetches, decodes and executes instructions autonomously from memory, without an external start strobe. Adds LDR/STR/HALT, a parametrised memory latency, a parametrised register-select width, and a retired-instruction counter. Drives the regfile, pipeline registers, ALU muxes, status register, PC, IR and memory command.

---
 rtl/cpu_control_seq_pkg.sv | 78 +++++++
 rtl/cpu_control_seq_mem_wait_ctr.sv | 30 +++
 rtl/cpu_control_seq.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_control_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_seq_pkg.sv
// rtl/cpu_control_seq_pkg.sv - shared state encoding, opcode and control-code constants
package cpu_control_seq_pkg;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,
        S_IF1       = 5'd1,
        S_IF2       = 5'd2,
        S_UPDATE_PC = 5'd3,
        S_DECODE    = 5'd4,
        S_MOV_IMM   = 5'd5,
        S_GET_A     = 5'd6,
        S_GET_B     = 5'd7,
        S_EXEC      = 5'd8,
        S_CMP       = 5'd9,
        S_WRITE_REG = 5'd10,
        S_ADDR      = 5'd11,
        S_LD_ADDR   = 5'd12,
        S_MEM_RD    = 5'd13,
        S_LOAD_REG  = 5'd14,
        S_GET_RD    = 5'd15,
        S_PASS      = 5'd16,
        S_MEM_WR    = 5'd17,
        S_HALT      = 5'd18
    } state_t;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV     = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MEM     = 2'b00;
    localparam logic [1:0] OP_HALT    = 2'b00;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_MDATA = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_PC    = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    function automatic state_t dispatch(input logic [2:0] opcode, input logic [1:0] op);
        state_t s;
        case ({opcode, op})
            {OPC_MOV, OP_MOV_IMM}:                    s = S_MOV_IMM;
            {OPC_MOV, OP_MOV}, {OPC_ALU, OP_MVN}:     s = S_GET_B;
            {OPC_ALU, OP_ADD}, {OPC_ALU, OP_CMP},
            {OPC_ALU, OP_AND}:                        s = S_GET_A;
            {OPC_LDR, OP_MEM}, {OPC_STR, OP_MEM}:     s = S_GET_A;
            default:                                  s = S_HALT;
        endcase
        return s;
    endfunction

    function automatic logic is_halt(input logic [2:0] opcode, input logic [1:0] op);
        return {opcode, op} == {OPC_HALT, OP_HALT};
    endfunction

    function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
        return (dispatch(opcode, op) != S_HALT) || is_halt(opcode, op);
    endfunction

endpackage

// File: rtl/cpu_control_seq_mem_wait_ctr.sv
// rtl/cpu_control_seq_mem_wait_ctr.sv - memory latency counter shared by fetch and data access
module mem_wait_ctr
    import cpu_control_seq_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);

    localparam logic [WAIT_W-1:0] LP_START = WAIT_W'(MEM_LAT - 1);

    logic [WAIT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LP_START;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WAIT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/cpu_control_seq.sv
// rtl/cpu_control_seq.sv - multi-cycle fetch/decode/execute control sequencer
module cpu_control_seq
    import cpu_control_seq_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned NSEL_W  = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [2:0]        i_opcode,
    input  logic [1:0]        i_op,
    output logic [1:0]        o_vsel,
    output logic              o_write,
    output logic              o_loada,
    output logic              o_loadb,
    output logic              o_asel,
    output logic              o_bsel,
    output logic              o_loadc,
    output logic              o_loads,
    output logic [NSEL_W-1:0] o_nsel,
    output logic              o_load_ir,
    output logic              o_load_pc,
    output logic              o_reset_pc,
    output logic              o_addr_sel,
    output logic              o_load_addr,
    output logic [1:0]        o_mem_cmd,
    output logic              o_halted,
    output logic              o_illegal,
    output logic [CNT_W-1:0]  o_instr_count
);

    state_t            r_state;
    state_t            w_next;
    logic              w_wait;
    logic              w_done;
    logic              w_ctr_load;
    logic              w_retire;
    logic              w_set_illegal;
    logic              w_is_cmp;
    logic              w_zero_a;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_count;

    assign w_is_cmp = (i_opcode == OPC_ALU) && (i_op == OP_CMP);
    assign w_zero_a = (i_opcode == OPC_MOV) || ((i_opcode == OPC_ALU) && (i_op == OP_MVN));

    assign w_wait     = (r_state == S_IF1) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // Reloading on every state change restarts the latency window even on MemWr -> IF1.
    assign w_ctr_load = (w_next != r_state);

    mem_wait_ctr #(.MEM_LAT(MEM_LAT)) u_wait (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_ctr_load),
        .i_dec   (w_wait),
        .o_done  (w_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_vsel      = VSEL_C;
        o_write     = 1'b0;
        o_loada     = 1'b0;
        o_loadb     = 1'b0;
        o_asel      = 1'b0;
        o_bsel      = 1'b0;
        o_loadc     = 1'b0;
        o_loads     = 1'b0;
        o_nsel      = NSEL_W'(NSEL_NONE);
        o_load_ir   = 1'b0;
        o_load_pc   = 1'b0;
        o_reset_pc  = 1'b0;
        o_addr_sel  = 1'b0;
        o_load_addr = 1'b0;
        o_mem_cmd   = MEM_NONE;
        o_halted    = 1'b0;
        unique case (r_state)
            S_RESET: begin
                o_reset_pc = 1'b1;
                o_load_pc  = 1'b1;
                w_next     = S_IF1;
            end
            S_IF1: begin
                o_addr_sel = 1'b1;
                o_mem_cmd  = MEM_READ;
                if (w_done) w_next = S_IF2;
            end
            S_IF2: begin
                o_addr_sel = 1'b1;
                o_mem_cmd  = MEM_READ;
                o_load_ir  = 1'b1;
                w_next     = S_UPDATE_PC;
            end
            S_UPDATE_PC: begin
                o_load_pc = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: w_next = dispatch(i_opcode, i_op);
            S_MOV_IMM: begin
                o_vsel  = VSEL_IMM8;
                o_write = 1'b1;
                o_nsel  = NSEL_W'(NSEL_RN);
                w_next  = S_IF1;
            end
            S_GET_A: begin
                o_loada = 1'b1;
                o_nsel  = NSEL_W'(NSEL_RN);
                w_next  = (i_opcode == OPC_ALU) ? S_GET_B : S_ADDR;
            end
            S_GET_B: begin
                o_loadb = 1'b1;
                o_nsel  = NSEL_W'(NSEL_RM);
                w_next  = w_is_cmp ? S_CMP : S_EXEC;
            end
            S_EXEC: begin
                o_loadc = 1'b1;
                o_asel  = w_zero_a;
                w_next  = S_WRITE_REG;
            end
            S_CMP: begin
                o_loads = 1'b1;
                w_next  = S_IF1;
            end
            S_WRITE_REG: begin
                o_vsel  = VSEL_C;
                o_write = 1'b1;
                o_nsel  = NSEL_W'(NSEL_RD);
                w_next  = S_IF1;
            end
            S_ADDR: begin
                o_bsel  = 1'b1;
                o_loadc = 1'b1;
                w_next  = S_LD_ADDR;
            end
            S_LD_ADDR: begin
                o_load_addr = 1'b1;
                w_next      = (i_opcode == OPC_LDR) ? S_MEM_RD : S_GET_RD;
            end
            S_MEM_RD: begin
                o_mem_cmd = MEM_READ;
                if (w_done) w_next = S_LOAD_REG;
            end
            S_LOAD_REG: begin
                o_mem_cmd = MEM_READ;
                o_vsel    = VSEL_MDATA;
                o_write   = 1'b1;
                o_nsel    = NSEL_W'(NSEL_RD);
                w_next    = S_IF1;
            end
            S_GET_RD: begin
                o_loadb = 1'b1;
                o_nsel  = NSEL_W'(NSEL_RD);
                w_next  = S_PASS;
            end
            S_PASS: begin
                o_asel  = 1'b1;
                o_loadc = 1'b1;
                w_next  = S_MEM_WR;
            end
            S_MEM_WR: begin
                o_mem_cmd = MEM_WRITE;
                if (w_done) w_next = S_IF1;
            end
            S_HALT: o_halted = 1'b1;
            default: w_next = S_RESET;
        endcase
    end

    // HALT retires on its way into sHalt; an undefined encoding only flags illegal.
    always_comb begin
        w_retire = 1'b0;
        unique case (r_state)
            S_MOV_IMM, S_CMP, S_WRITE_REG, S_LOAD_REG: w_retire = 1'b1;
            S_MEM_WR:                                  w_retire = w_done;
            S_DECODE:                                  w_retire = is_halt(i_opcode, i_op);
            default:                                   w_retire = 1'b0;
        endcase
    end

    assign w_set_illegal = (r_state == S_DECODE) && !is_legal(i_opcode, i_op);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_retire && (r_count != '1)) r_count <= r_count + CNT_W'(1);
            if (w_set_illegal) r_illegal <= 1'b1;
        end
    end

    assign o_illegal     = r_illegal;
    assign o_instr_count = r_count;

endmodule

// File: tb/tb_cpu_control_seq.sv
// tb/tb_cpu_control_seq.sv - randomized bench for cpu_control_seq at MEM_LAT 1 and 3
module tb_cpu_control_seq;

    typedef struct packed {
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic       loadc;
        logic       loads;
        logic [2:0] nsel;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       halted;
    } ob_t;

    typedef struct packed {
        ob_t  o;
        logic inc;
        logic ill;
    } step_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic [2:0]  opc      [2];
    logic [1:0]  opx      [2];
    logic [1:0]  vsel     [2];
    logic        write    [2];
    logic        loada    [2];
    logic        loadb    [2];
    logic        asel     [2];
    logic        bsel     [2];
    logic        loadc    [2];
    logic        loads    [2];
    logic [2:0]  nsel     [2];
    logic        load_ir  [2];
    logic        load_pc  [2];
    logic        reset_pc [2];
    logic        addr_sel [2];
    logic        load_addr[2];
    logic [1:0]  mem_cmd  [2];
    logic        halted   [2];
    logic        illegal  [2];
    logic [15:0] cnt      [2];

    int          total = 0;
    int          bad   = 0;
    int          m_cnt [2];
    logic        m_ill [2];
    step_t       q[$];
    logic [4:0]  legal_ops [8] = '{5'b11010, 5'b11000, 5'b10111, 5'b10100,
                                   5'b10101, 5'b10110, 5'b01100, 5'b10000};

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        cpu_control_seq #(.MEM_LAT(g == 0 ? 1 : 3), .NSEL_W(3), .CNT_W(16)) dut (
            .i_clk        (clk),
            .i_reset      (rst[g]),
            .i_opcode     (opc[g]),
            .i_op         (opx[g]),
            .o_vsel       (vsel[g]),
            .o_write      (write[g]),
            .o_loada      (loada[g]),
            .o_loadb      (loadb[g]),
            .o_asel       (asel[g]),
            .o_bsel       (bsel[g]),
            .o_loadc      (loadc[g]),
            .o_loads      (loads[g]),
            .o_nsel       (nsel[g]),
            .o_load_ir    (load_ir[g]),
            .o_load_pc    (load_pc[g]),
            .o_reset_pc   (reset_pc[g]),
            .o_addr_sel   (addr_sel[g]),
            .o_load_addr  (load_addr[g]),
            .o_mem_cmd    (mem_cmd[g]),
            .o_halted     (halted[g]),
            .o_illegal    (illegal[g]),
            .o_instr_count(cnt[g])
        );
    end

    function automatic ob_t obs_of(input int d);
        ob_t r;
        r = {vsel[d], write[d], loada[d], loadb[d], asel[d], bsel[d], loadc[d], loads[d],
             nsel[d], load_ir[d], load_pc[d], reset_pc[d], addr_sel[d], load_addr[d],
             mem_cmd[d], halted[d]};
        return r;
    endfunction

    function automatic bit is_legal5(input logic [4:0] c);
        bit r;
        r = (c == 5'b11100);
        for (int i = 0; i < 8; i++) if (legal_ops[i] == c) r = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input ob_t o, input logic inc = 1'b0, input logic ill = 1'b0);
        step_t s;
        s.o = o; s.inc = inc; s.ill = ill;
        q.push_back(s);
    endtask

    // Expected per-cycle outputs for one instruction, written from the instruction's step list.
    task automatic gen(input int lat, input logic [4:0] code, output bit retires);
        ob_t o;
        string k;
        case (code)
            5'b11010: k = "MOVI";  5'b11000: k = "MOV";  5'b10111: k = "MVN";
            5'b10100: k = "ADD";   5'b10101: k = "CMP";  5'b10110: k = "AND";
            5'b01100: k = "LDR";   5'b10000: k = "STR";  5'b11100: k = "HALT";
            default:  k = "ILL";
        endcase
        o = '0; o.addr_sel = 1; o.mem_cmd = 2'b01;
        repeat (lat) push(o);
        o.load_ir = 1; push(o);
        o = '0; o.load_pc = 1; push(o);
        o = '0; push(o);
        retires = !(k == "HALT" || k == "ILL");
        if (k == "ADD" || k == "AND" || k == "CMP" || k == "LDR" || k == "STR") begin
            o = '0; o.loada = 1; o.nsel = 3'b100; push(o);
        end
        if (k == "MOVI") begin
            o = '0; o.vsel = 2'b10; o.write = 1; o.nsel = 3'b100; push(o);
        end else if (k == "MOV" || k == "MVN" || k == "ADD" || k == "AND" || k == "CMP") begin
            o = '0; o.loadb = 1; o.nsel = 3'b001; push(o);
            if (k == "CMP") begin
                o = '0; o.loads = 1; push(o);
            end else begin
                o = '0; o.loadc = 1; o.asel = (k == "MOV" || k == "MVN"); push(o);
                o = '0; o.write = 1; o.nsel = 3'b010; push(o);
            end
        end else if (k == "LDR" || k == "STR") begin
            o = '0; o.bsel = 1; o.loadc = 1; push(o);
            o = '0; o.load_addr = 1; push(o);
            if (k == "LDR") begin
                o = '0; o.mem_cmd = 2'b01; repeat (lat) push(o);
                o.vsel = 2'b01; o.write = 1; o.nsel = 3'b010; push(o);
            end else begin
                o = '0; o.loadb = 1; o.nsel = 3'b010; push(o);
                o = '0; o.asel = 1; o.loadc = 1; push(o);
                o = '0; o.mem_cmd = 2'b10; repeat (lat) push(o);
            end
        end else begin
            o = '0; o.halted = 1;
            push(o, k == "HALT", k == "ILL");
            repeat (6) push(o);
        end
    endtask

    task automatic play(input int d, input bit stop_wr);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(posedge clk); #1;
            if (s.inc && m_cnt[d] < 65535) m_cnt[d]++;
            if (s.ill) m_ill[d] = 1'b1;
            chk($sformatf("d%0d outs", d), 32'(obs_of(d)), 32'(s.o));
            chk($sformatf("d%0d count", d), 32'(cnt[d]), 32'(m_cnt[d]));
            chk($sformatf("d%0d illegal", d), 32'(illegal[d]), 32'(m_ill[d]));
            if (stop_wr && s.o.mem_cmd == 2'b10) q.delete();
        end
    endtask

    task automatic run(input int d, input logic [4:0] code, input bit stop_wr = 1'b0);
        bit ret;
        opc[d] = code[4:2];
        opx[d] = code[1:0];
        gen(d == 0 ? 1 : 3, code, ret);
        play(d, stop_wr);
        if (ret && m_cnt[d] < 65535) m_cnt[d]++;
    endtask

    task automatic check_reset_state(input int d);
        ob_t o;
        o = '0; o.reset_pc = 1; o.load_pc = 1;
        chk($sformatf("d%0d reset outs", d), 32'(obs_of(d)), 32'(o));
        chk($sformatf("d%0d reset count", d), 32'(cnt[d]), 32'd0);
        chk($sformatf("d%0d reset illegal", d), 32'(illegal[d]), 32'd0);
    endtask

    task automatic reset_dut(input int d);
        rst[d] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst[d] = 1'b0;
        m_cnt[d] = 0;
        m_ill[d] = 1'b0;
        check_reset_state(d);
    endtask

    initial begin
        logic [4:0] c;
        ob_t        o;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; opc[d] = 3'b110; opx[d] = 2'b10;
            m_cnt[d] = 0; m_ill[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst[0] = 1'b0; rst[1] = 1'b0;
        check_reset_state(0);
        check_reset_state(1);

        for (int d = 0; d < 2; d++) begin
            if (d == 1) reset_dut(1);
            for (int i = 0; i < 8; i++) run(d, legal_ops[i]);
            for (int i = 0; i < 25; i++) run(d, legal_ops[$urandom_range(0, 7)]);
            run(d, 5'b11100);
            reset_dut(d);
            run(d, 5'b00100);
            reset_dut(d);
            do c = 5'($urandom_range(0, 31)); while (is_legal5(c));
            run(d, c);
        end

        reset_dut(1);
        run(1, 5'b11010);
        run(1, 5'b10000, 1'b1);
        #2 rst[1] = 1'b1;
        #1;
        o = '0; o.reset_pc = 1; o.load_pc = 1;
        chk("async mem_cmd", 32'(mem_cmd[1]), 32'd0);
        chk("async outs", 32'(obs_of(1)), 32'(o));
        chk("async illegal", 32'(illegal[1]), 32'd0);
        chk("async count", 32'(cnt[1]), 32'd0);
        @(posedge clk); #1 rst[1] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
